writeback_regfile: RTL

- Writeback stage of the pipelined RV32I core; consumes the W-stage control (RegWrite_W, ResultSrc_W) and data latched by the M→W pipeline registers.
- Selects the final result, formats load data, and writes the 32-entry integer register file.
- Serves Decode's two read ports with same-cycle write bypass, so no negedge write is needed.
- Drives Result_W to the hazard/forwarding network and keeps a 64-bit retired-instruction counter.

---
 rtl/core_pkg.sv | 19 +
 rtl/writeback_regfile_load_formatter.sv | 37 +++
 rtl/writeback_regfile.sv | 92 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: result-source and load funct3 encodings
// plus common index and word types.
package core_pkg;

   localparam logic [1:0] RESULT_ALU  = 2'b00;
   localparam logic [1:0] RESULT_LOAD = 2'b01;
   localparam logic [1:0] RESULT_PC4  = 2'b10;
   localparam logic [1:0] RESULT_IMM  = 2'b11;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] word_t;

endpackage

// File: rtl/writeback_regfile_load_formatter.sv
// Extracts and extends the addressed byte/halfword of a loaded word and
// flags accesses that are not naturally aligned for their size.
module load_formatter
   import core_pkg::*;
(
   input  word_t      i_ReadData_W,
   input  logic [1:0] i_off,
   input  logic [2:0] i_Funct3_W,
   output word_t      o_LoadData,
   output logic       o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte     = i_ReadData_W[{i_off, 3'b000} +: 8];
      w_half     = i_ReadData_W[{i_off[1], 4'b0000} +: 16];
      o_LoadData = i_ReadData_W;
      o_misalign = 1'b0;
      case (i_Funct3_W)
         LB:  o_LoadData = {{24{w_byte[7]}}, w_byte};
         LBU: o_LoadData = {24'h000000, w_byte};
         LH:  begin
            o_LoadData = {{16{w_half[15]}}, w_half};
            o_misalign = i_off[0];
         end
         LHU: begin
            o_LoadData = {16'h0000, w_half};
            o_misalign = i_off[0];
         end
         LW:  o_misalign = |i_off;
         default: ;
      endcase
   end

endmodule

// File: rtl/writeback_regfile.sv
// RV32I writeback stage: result select, load formatting, 32-entry register
// file with write-first read bypass, and a 64-bit retired-instruction counter.
module writeback_regfile
   import core_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NREGS      = 32,
   parameter int RESET_REGS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     RegWrite_W,
   input  logic [1:0]               ResultSrc_W,
   input  logic                     Valid_W,
   input  logic [$clog2(NREGS)-1:0] Rd_W,
   input  logic [2:0]               Funct3_W,
   input  logic [XLEN-1:0]          ALUResult_W,
   input  logic [XLEN-1:0]          ReadData_W,
   input  logic [XLEN-1:0]          PCPlus4_W,
   input  logic [XLEN-1:0]          ImmExt_W,
   input  logic [$clog2(NREGS)-1:0] A1_D,
   input  logic [$clog2(NREGS)-1:0] A2_D,
   output logic [XLEN-1:0]          RD1_D,
   output logic [XLEN-1:0]          RD2_D,
   output logic [XLEN-1:0]          Result_W,
   output logic                     LoadMisalign_W,
   output logic [63:0]              Instret
);

   logic [XLEN-1:0] r_regs [NREGS];
   logic [63:0]     r_instret;
   word_t           w_load_data;
   logic            w_misalign;
   logic            w_we;

   load_formatter u_load_formatter (
      .i_ReadData_W (ReadData_W),
      .i_off        (ALUResult_W[1:0]),
      .i_Funct3_W   (Funct3_W),
      .o_LoadData   (w_load_data),
      .o_misalign   (w_misalign)
   );

   always_comb begin
      Result_W = ALUResult_W;
      case (ResultSrc_W)
         RESULT_ALU:  Result_W = ALUResult_W;
         RESULT_LOAD: Result_W = w_load_data;
         RESULT_PC4:  Result_W = PCPlus4_W;
         RESULT_IMM:  Result_W = ImmExt_W;
         default:     Result_W = ALUResult_W;
      endcase
   end

   assign LoadMisalign_W = Valid_W & (ResultSrc_W == RESULT_LOAD) & w_misalign;

   // Reset also blocks the bypass so reads see the cleared array during reset.
   assign w_we = RegWrite_W & Valid_W & (Rd_W != '0) & ~reset;

   generate
      if (RESET_REGS != 0) begin : g_reset_regs
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
            end else if (w_we) begin
               r_regs[Rd_W] <= Result_W;
            end
         end
      end else begin : g_plain_regs
         always_ff @(posedge clk) begin
            if (w_we) r_regs[Rd_W] <= Result_W;
         end
      end
   endgenerate

   always_comb begin
      RD1_D = r_regs[A1_D];
      if (A1_D == '0)                 RD1_D = '0;
      else if (w_we && A1_D == Rd_W)  RD1_D = Result_W;
      RD2_D = r_regs[A2_D];
      if (A2_D == '0)                 RD2_D = '0;
      else if (w_we && A2_D == Rd_W)  RD2_D = Result_W;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_instret <= '0;
      else if (Valid_W) r_instret <= r_instret + 64'd1;
   end

   assign Instret = r_instret;

endmodule
